// File: rtl/rgb565_gray_packer_ci_pkg.sv
// Shared definitions for the RGB565-to-gray packing custom instruction:
// opcodes, controller states, luma weights and the status-word layout.
package rgb565_gray_packer_ci_pkg;

  typedef enum logic [1:0] {
    OP_PUSH2 = 2'd0,
    OP_READ  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_PUSH1 = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV0 = 2'd1,
    ST_CONV1 = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Weights sum to 256, so a 6-bit-per-channel pixel scales to a 14-bit sum.
  localparam logic [14:0] W_R        = 15'd54;
  localparam logic [14:0] W_G        = 15'd183;
  localparam logic [14:0] W_B        = 15'd19;
  localparam int          GRAY_SHIFT = 6;
  localparam logic [2:0]  COUNT_FULL = 3'd4;

  function automatic logic [31:0] status_word(input logic ovf, input logic [2:0] count);
    return {27'd0, ovf, 1'b0, count};
  endfunction

endpackage

// File: rtl/rgb565_gray_core.sv
// Combinational RGB565 to 8-bit gray converter; channels widened to 6 bits
// before the weighted sum so all three share one scale.
module rgb565_gray_core
  import rgb565_gray_packer_ci_pkg::*;
(
  input  logic [15:0] pixel,
  output logic [7:0]  gray
);

  logic [14:0] r6;
  logic [14:0] g6;
  logic [14:0] b6;
  logic [14:0] sum;

  assign r6  = {9'd0, pixel[15:11], 1'b0};
  assign g6  = {9'd0, pixel[10:5]};
  assign b6  = {9'd0, pixel[4:0], 1'b0};
  assign sum = r6 * W_R + g6 * W_G + b6 * W_B;

  // Maximum sum is 16055, so bits [13:6] never lose a carry.
  assign gray = 8'(sum >> GRAY_SHIFT);

endmodule

// File: rtl/rgb565_gray_packer_ci.sv
// Custom-instruction controller: converts one or two pushed pixels through a
// shared gray core and packs the bytes little-endian into a 32-bit word.
module rgb565_gray_packer_ci
  import rgb565_gray_packer_ci_pkg::*;
#(
  parameter logic [7:0] customInstructionId = 8'd0
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic        ciStart,
  input  logic        ciCke,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic        ciDone,
  output logic [31:0] ciResult
);

  state_e      state_q,  state_d;
  op_e         op_q,     op_d;
  logic [31:0] pix_q,    pix_d;
  logic [31:0] buf_q,    buf_d;
  logic [2:0]  count_q,  count_d;
  logic        ovf_q,    ovf_d;
  logic        done_q,   done_d;
  logic [31:0] result_q, result_d;

  op_e         op_in;
  logic        accept;
  logic        conv_active;
  logic [15:0] core_pixel;
  logic [7:0]  core_gray;
  logic        unused_op_bits;

  assign op_in          = op_e'(ciValueB[1:0]);
  assign unused_op_bits = ^ciValueB[31:2];
  assign accept         = ciStart && (ciN == customInstructionId);
  assign conv_active    = (state_q == ST_CONV0) || (state_q == ST_CONV1);
  assign core_pixel     = (state_q == ST_CONV1) ? pix_q[31:16] : pix_q[15:0];

  rgb565_gray_core u_core (
    .pixel (core_pixel),
    .gray  (core_gray)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    pix_d    = pix_q;
    buf_d    = buf_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    done_d   = done_q;
    result_d = result_q;

    if (ciCke) begin
      done_d   = 1'b0;
      result_d = 32'd0;

      if (conv_active) begin
        if (count_q == COUNT_FULL) begin
          ovf_d = 1'b1;
        end else begin
          buf_d[{count_q[1:0], 3'b000} +: 8] = core_gray;
          count_d                            = count_q + 3'd1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_d  = op_in;
            pix_d = ciValueA;
            case (op_in)
              OP_PUSH2, OP_PUSH1: state_d = ST_CONV0;
              default: begin
                // READ returns the word before the clear lands on the same edge.
                state_d  = ST_DONE;
                done_d   = 1'b1;
                result_d = (op_in == OP_READ) ? buf_q : 32'd0;
                buf_d    = 32'd0;
                count_d  = 3'd0;
                ovf_d    = 1'b0;
              end
            endcase
          end
        end
        ST_CONV0: begin
          if (op_q == OP_PUSH2) begin
            state_d = ST_CONV1;
          end else begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = status_word(ovf_d, count_d);
          end
        end
        ST_CONV1: begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          result_d = status_word(ovf_d, count_d);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_PUSH2;
      pix_q    <= 32'd0;
      buf_q    <= 32'd0;
      count_q  <= 3'd0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      pix_q    <= pix_d;
      buf_q    <= buf_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign ciDone   = done_q;
  assign ciResult = result_q;

endmodule

// File: tb/tb_rgb565_gray_packer_ci.sv
// Self-checking bench for rgb565_gray_packer_ci: directed scenarios plus
// random operations checked against a byte-queue reference model.
module tb_rgb565_gray_packer_ci;

  localparam logic [7:0] ID = 8'h2A;

  logic        clock = 1'b0;
  logic        nReset;
  logic        ciStart;
  logic        ciCke;
  logic [7:0]  ciN;
  logic [31:0] ciValueA;
  logic [31:0] ciValueB;
  logic        ciDone;
  logic [31:0] ciResult;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_bytes[$];
  bit         m_ovf;

  rgb565_gray_packer_ci #(.customInstructionId(ID)) dut (
    .clock    (clock),
    .nReset   (nReset),
    .ciStart  (ciStart),
    .ciCke    (ciCke),
    .ciN      (ciN),
    .ciValueA (ciValueA),
    .ciValueB (ciValueB),
    .ciDone   (ciDone),
    .ciResult (ciResult)
  );

  always #5 clock = ~clock;

  // Result must read zero in every cycle without a completion pulse.
  always @(negedge clock) begin
    n_vec++;
    if (ciDone === 1'b0 && ciResult !== 32'd0) begin
      n_err++;
      $display("FAIL idle_result_zero: got %h, want 00000000 at %0t", ciResult, $time);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_gray(input logic [15:0] p);
    int r6, g6, b6;
    r6 = int'(p[15:11]) * 2;
    g6 = int'(p[10:5]);
    b6 = int'(p[4:0]) * 2;
    return 8'((r6 * 54 + g6 * 183 + b6 * 19) / 64);
  endfunction

  task automatic m_push(input logic [15:0] p);
    if (m_bytes.size() < 4) m_bytes.push_back(ref_gray(p));
    else m_ovf = 1'b1;
  endtask

  function automatic logic [31:0] m_status();
    return (m_ovf ? 32'h10 : 32'h0) | 32'(m_bytes.size());
  endfunction

  function automatic logic [31:0] m_word();
    logic [31:0] w = 32'd0;
    foreach (m_bytes[i]) w = w | (32'(m_bytes[i]) << (8 * i));
    return w;
  endfunction

  task automatic m_clear();
    m_bytes.delete();
    m_ovf = 1'b0;
  endtask

  task automatic model_apply(input logic [1:0] op, input logic [31:0] a,
                             output int lat, output logic [31:0] res);
    case (op)
      2'd0: begin m_push(a[15:0]); m_push(a[31:16]); lat = 3; res = m_status(); end
      2'd3: begin m_push(a[15:0]); lat = 2; res = m_status(); end
      2'd1: begin res = m_word(); m_clear(); lat = 1; end
      default: begin res = 32'd0; m_clear(); lat = 1; end
    endcase
  endtask

  // ---------------- stimulus ----------------
  task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [7:0] n);
    logic [31:0] junk;
    junk     = $urandom();
    ciStart  = 1'b1;
    ciN      = n;
    ciValueA = a;
    ciValueB = {junk[31:2], op};
  endtask

  // Called at a negedge; returns cycles to ciDone (-1 on timeout), the
  // result sampled with ciDone, and ciDone one cycle later.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        output int lat, output logic [31:0] res, output logic tail);
    drive_start(op, a, ID);
    @(negedge clock);
    ciStart = 1'b0;
    lat = 1;
    while (ciDone !== 1'b1 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    if (ciDone !== 1'b1) lat = -1;
    res = ciResult;
    @(negedge clock);
    tail = ciDone;
  endtask

  task automatic test_reset();
    nReset  = 1'b0;
    ciStart = 1'b0;
    ciCke   = 1'b1;
    ciN     = 8'd0;
    ciValueA = 32'd0;
    ciValueB = 32'd0;
    m_clear();
    repeat (3) @(negedge clock);
    n_vec++;
    if (ciDone !== 1'b0 || ciResult !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got done=%b result=%h, want done=0 result=00000000", ciDone, ciResult);
    end
    nReset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_push2_read();
    int lat, elat;
    logic [31:0] res, eres;
    logic tail;
    run_op(2'd0, 32'h07E0_FFFF, lat, res, tail);
    model_apply(2'd0, 32'h07E0_FFFF, elat, eres);
    n_vec++;
    if (lat !== 3 || res !== 32'h2 || tail !== 1'b0) begin
      n_err++;
      $display("FAIL push2_first: got lat=%0d res=%h tail=%b, want lat=3 res=00000002 tail=0", lat, res, tail);
    end
    run_op(2'd1, 32'd0, lat, res, tail);
    model_apply(2'd1, 32'd0, elat, eres);
    n_vec++;
    if (lat !== 1 || res !== 32'h0000_B4FA) begin
      n_err++;
      $display("FAIL read_first: got lat=%0d res=%h, want lat=1 res=0000b4fa", lat, res);
    end
  endtask

  task automatic test_pack_order();
    logic [31:0] px[3] = '{32'h0000_F800, 32'h0000_001F, 32'h0000_0000};
    logic [1:0]  ops[3] = '{2'd3, 2'd3, 2'd0};
    logic [31:0] want[3] = '{32'd1, 32'd2, 32'd4};
    int lat, elat;
    logic [31:0] res, eres;
    logic tail;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], px[i], lat, res, tail);
      model_apply(ops[i], px[i], elat, eres);
      n_vec++;
      if (lat !== elat || res !== want[i]) begin
        n_err++;
        $display("FAIL pack_step%0d: got lat=%0d res=%h, want lat=%0d res=%h", i, lat, res, elat, want[i]);
      end
    end
    run_op(2'd1, 32'd0, lat, res, tail);
    model_apply(2'd1, 32'd0, elat, eres);
    n_vec++;
    if (res !== 32'h0000_1234) begin
      n_err++;
      $display("FAIL pack_read: got %h, want 00001234", res);
    end
  endtask

  task automatic test_overflow();
    int lat, elat;
    logic [31:0] res, eres, a;
    logic tail;
    for (int i = 0; i < 3; i++) begin
      a = $urandom();
      run_op(2'd3, a, lat, res, tail);
      model_apply(2'd3, a, elat, eres);
    end
    run_op(2'd0, 32'hFFFF_FFFF, lat, res, tail);
    model_apply(2'd0, 32'hFFFF_FFFF, elat, eres);
    n_vec++;
    if (res !== 32'h14) begin
      n_err++;
      $display("FAIL ovf_status: got %h, want 00000014", res);
    end
    run_op(2'd1, 32'd0, lat, res, tail);
    model_apply(2'd1, 32'd0, elat, eres);
    n_vec++;
    if (res !== eres || res[31:24] !== 8'hFA) begin
      n_err++;
      $display("FAIL ovf_read: got %h, want %h (byte3=fa)", res, eres);
    end
    run_op(2'd3, 32'h0000_1234, lat, res, tail);
    model_apply(2'd3, 32'h0000_1234, elat, eres);
    n_vec++;
    if (res !== 32'h1) begin
      n_err++;
      $display("FAIL ovf_cleared: got %h, want 00000001", res);
    end
  endtask

  task automatic test_ignored_starts();
    int lat, elat, done_seen;
    logic [31:0] res, eres;
    logic tail;
    drive_start(2'd3, 32'hFFFF_FFFF, ID ^ 8'h01);
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      ciStart = 1'b0;
      if (ciDone === 1'b1) done_seen++;
    end
    n_vec++;
    if (done_seen !== 0) begin
      n_err++;
      $display("FAIL wrong_id_done: got %0d pulses, want 0", done_seen);
    end
    // A READ strobed during CONV0 of a PUSH2 must be ignored.
    drive_start(2'd0, 32'h001F_F800, ID);
    @(negedge clock);
    drive_start(2'd1, 32'd0, ID);
    @(negedge clock);
    ciStart = 1'b0;
    lat = 2;
    while (ciDone !== 1'b1 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    res = ciResult;
    model_apply(2'd0, 32'h001F_F800, elat, eres);
    n_vec++;
    if (lat !== 3 || res !== eres) begin
      n_err++;
      $display("FAIL busy_start: got lat=%0d res=%h, want lat=3 res=%h", lat, res, eres);
    end
    done_seen = 0;
    repeat (4) begin
      @(negedge clock);
      if (ciDone === 1'b1) done_seen++;
    end
    n_vec++;
    if (done_seen !== 0) begin
      n_err++;
      $display("FAIL busy_extra_done: got %0d pulses, want 0", done_seen);
    end
    run_op(2'd1, 32'd0, lat, res, tail);
    model_apply(2'd1, 32'd0, elat, eres);
    n_vec++;
    if (res !== eres) begin
      n_err++;
      $display("FAIL ignored_read: got %h, want %h", res, eres);
    end
  endtask

  task automatic test_cke_freeze();
    int elat, bad;
    logic [31:0] eres;
    drive_start(2'd0, 32'hA5A5_5A5A, ID);
    @(negedge clock);
    ciStart = 1'b0;
    @(negedge clock);
    ciCke = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clock);
      if (ciDone !== 1'b0) bad++;
    end
    ciCke = 1'b1;
    @(negedge clock);
    model_apply(2'd0, 32'hA5A5_5A5A, elat, eres);
    n_vec++;
    if (bad !== 0 || ciDone !== 1'b1 || ciResult !== eres) begin
      n_err++;
      $display("FAIL cke_conv1: got early=%0d done=%b res=%h, want early=0 done=1 res=%h", bad, ciDone, ciResult, eres);
    end
    ciCke = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clock);
      if (ciDone !== 1'b1 || ciResult !== eres) bad++;
    end
    ciCke = 1'b1;
    @(negedge clock);
    n_vec++;
    if (bad !== 0 || ciDone !== 1'b0) begin
      n_err++;
      $display("FAIL cke_done_hold: got lost=%0d done_after=%b, want lost=0 done_after=0", bad, ciDone);
    end
  endtask

  task automatic test_reset_abort();
    int lat, elat, done_seen;
    logic [31:0] res, eres;
    logic tail;
    drive_start(2'd0, 32'hFFFF_FFFF, ID);
    @(negedge clock);
    ciStart = 1'b0;
    nReset  = 1'b0;
    #1;
    n_vec++;
    if (ciDone !== 1'b0 || ciResult !== 32'd0) begin
      n_err++;
      $display("FAIL abort_outputs: got done=%b res=%h, want done=0 res=00000000", ciDone, ciResult);
    end
    m_clear();
    @(negedge clock);
    nReset = 1'b1;
    done_seen = 0;
    repeat (5) begin
      @(negedge clock);
      if (ciDone === 1'b1) done_seen++;
    end
    n_vec++;
    if (done_seen !== 0) begin
      n_err++;
      $display("FAIL abort_done: got %0d pulses, want 0", done_seen);
    end
    run_op(2'd1, 32'd0, lat, res, tail);
    model_apply(2'd1, 32'd0, elat, eres);
    n_vec++;
    if (res !== 32'd0) begin
      n_err++;
      $display("FAIL abort_read: got %h, want 00000000", res);
    end
  endtask

  task automatic test_random();
    int lat, elat;
    logic [31:0] res, eres, a;
    logic [1:0] op;
    logic tail;
    for (int i = 0; i < 60; i++) begin
      a  = $urandom();
      // Bias toward pushes so the buffer regularly fills and overflows.
      op = ($urandom_range(0, 9) < 7) ? ($urandom_range(0, 1) ? 2'd0 : 2'd3)
                                       : ($urandom_range(0, 3) != 0 ? 2'd1 : 2'd2);
      run_op(op, a, lat, res, tail);
      model_apply(op, a, elat, eres);
      n_vec++;
      if (lat !== elat || res !== eres || tail !== 1'b0) begin
        n_err++;
        $display("FAIL random_%0d op=%0d a=%h: got lat=%0d res=%h tail=%b, want lat=%0d res=%h tail=0",
                 i, op, a, lat, res, tail, elat, eres);
      end
    end
  endtask

  initial begin
    test_reset();
    test_push2_read();
    test_pack_order();
    test_overflow();
    test_ignored_starts();
    test_cke_freeze();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
